// File: rtl/zx_ula_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : zx_ula_port_ctrl
// Description : ULA-side port FE controller. Scans an 8x5 key matrix with a
//               row-strobe FSM, holds the key state in a 40-bit register,
//               answers CPU IN on port FE with the half-rows selected by
//               A15..A8, latches border/MIC/EAR on OUT and generates the
//               periodic frame /INT pulse.
//               Optional feature macro: ZX_KBD_DEBOUNCE_EN (per-row debounce
//               of DEBOUNCE_SCANS identical samples; direct update otherwise).
// Revision    : 1.0 - initial release
// ============================================================================
module zx_ula_port_ctrl #(
  parameter int FRAME_CYCLES   = 69888,
  parameter int INT_CYCLES     = 32,
  parameter int SETTLE_CYCLES  = 16,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic [15:0] ad,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        data_oe,
  output logic [7:0]  kbd_row_n,
  input  logic [4:0]  kbd_col_n,
  input  logic        ear_in,
  output logic [2:0]  border,
  output logic        mic_out,
  output logic        ear_out,
  output logic        int_n,
  output logic        frame_start
);

  localparam int FW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [FW-1:0] C_FRAME_LAST  = FW'(FRAME_CYCLES - 1);
  localparam logic [FW-1:0] C_INT_CYCLES  = FW'(INT_CYCLES);
  localparam logic [SW-1:0] C_SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_DRIVE  = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_NEXT   = 2'd2
  } scan_state_e;

  scan_state_e     state_q, state_d;
  logic [2:0]      row_q, row_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic [4:0]      samp_q, samp_d;
  logic [7:0]      row_n_q, row_n_d;
  logic [7:0][4:0] keys_q, keys_d;
  logic            wr_sel_q, wr_sel_d;
  logic [2:0]      border_q, border_d;
  logic            mic_q, mic_d;
  logic            ear_q, ear_d;
  logic [FW-1:0]   fcnt_q, fcnt_d;
  logic            int_n_q, int_n_d;
  logic            fs_q, fs_d;

  logic            rd_sel;
  logic            wr_sel;
  logic [4:0]      k_comb;
  logic            unused_bits;

`ifdef ZX_KBD_DEBOUNCE_EN
  localparam int CW = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS + 1) : 1;
  localparam logic [CW-1:0] C_DEB = CW'(DEBOUNCE_SCANS);
  logic [7:0][4:0]    last_q, last_d;
  logic [7:0][CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0]      cnt_inc;
`endif

  // Bus decode: a cycle with both strobes low selects neither direction.
  assign rd_sel      = !ce && !rd_n && wr_n && !ad[0];
  assign wr_sel      = !ce && !wr_n && rd_n && !ad[0];
  assign unused_bits = ^{ad[7:1], data_in[7:5]};

  // Port FE read data: AND of every half-row whose address line is low.
  always_comb begin
    k_comb = 5'h1F;
    for (int r = 0; r < 8; r++) begin
      if (!ad[8+r]) k_comb = k_comb & keys_q[r];
    end
  end

  assign data_out = {1'b1, ear_in, 1'b1, k_comb};
  assign data_oe  = rd_sel;

  // Row-strobe scanner: settle, sample, then one all-high gap before next row.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    settle_d = settle_q;
    samp_d   = samp_q;
    case (state_q)
      ST_DRIVE: begin
        if (settle_q == C_SETTLE_LAST) begin
          settle_d = '0;
          state_d  = ST_SAMPLE;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      ST_SAMPLE: begin
        samp_d  = kbd_col_n;
        state_d = ST_NEXT;
      end
      ST_NEXT: begin
        row_d   = row_q + 3'd1;
        state_d = ST_DRIVE;
      end
      default: state_d = ST_DRIVE;
    endcase
    // Strobes are registered from the next state so the connector sees clean edges.
    row_n_d = (state_d == ST_NEXT) ? 8'hFF : ~(8'h01 << row_d);
  end

  // Key-state update for the row just sampled, applied during its NEXT cycle.
  always_comb begin
    keys_d = keys_q;
`ifdef ZX_KBD_DEBOUNCE_EN
    last_d  = last_q;
    cnt_d   = cnt_q;
    cnt_inc = cnt_q[row_q];
    if (state_q == ST_NEXT) begin
      if (samp_q != last_q[row_q]) begin
        // Any change restarts the stability count for this row.
        last_d[row_q] = samp_q;
        cnt_d[row_q]  = CW'(1);
      end else begin
        cnt_inc       = (cnt_q[row_q] == C_DEB) ? C_DEB : cnt_q[row_q] + 1'b1;
        cnt_d[row_q]  = cnt_inc;
        if (cnt_inc == C_DEB) keys_d[row_q] = last_q[row_q];
      end
    end
`else
    if (state_q == ST_NEXT) keys_d[row_q] = samp_q;
`endif
  end

  // OUT capture on the leading cycle of a write select only.
  always_comb begin
    wr_sel_d = wr_sel;
    border_d = border_q;
    mic_d    = mic_q;
    ear_d    = ear_q;
    if (wr_sel && !wr_sel_q) begin
      border_d = data_in[2:0];
      mic_d    = data_in[3];
      ear_d    = data_in[4];
    end
  end

  // Frame timer; outputs are registered decodes of the current count.
  always_comb begin
    fcnt_d  = (fcnt_q == C_FRAME_LAST) ? '0 : fcnt_q + 1'b1;
    int_n_d = !(fcnt_q < C_INT_CYCLES);
    fs_d    = (fcnt_q == '0);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_DRIVE;
      row_q    <= 3'd0;
      settle_q <= '0;
      samp_q   <= 5'h1F;
      row_n_q  <= 8'hFE;
      keys_q   <= '1;
      wr_sel_q <= 1'b0;
      border_q <= 3'd0;
      mic_q    <= 1'b0;
      ear_q    <= 1'b0;
      fcnt_q   <= '0;
      int_n_q  <= 1'b1;
      fs_q     <= 1'b0;
`ifdef ZX_KBD_DEBOUNCE_EN
      last_q   <= '1;
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      settle_q <= settle_d;
      samp_q   <= samp_d;
      row_n_q  <= row_n_d;
      keys_q   <= keys_d;
      wr_sel_q <= wr_sel_d;
      border_q <= border_d;
      mic_q    <= mic_d;
      ear_q    <= ear_d;
      fcnt_q   <= fcnt_d;
      int_n_q  <= int_n_d;
      fs_q     <= fs_d;
`ifdef ZX_KBD_DEBOUNCE_EN
      last_q   <= last_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign kbd_row_n   = row_n_q;
  assign border      = border_q;
  assign mic_out     = mic_q;
  assign ear_out     = ear_q;
  assign int_n       = int_n_q;
  assign frame_start = fs_q;

endmodule
`default_nettype wire

// File: tb/tb_zx_ula_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_zx_ula_port_ctrl
// Description : Directed scoreboard bench for zx_ula_port_ctrl with a short
//               frame (100 cycles, 4-cycle /INT) and a modelled ENTER key.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_zx_ula_port_ctrl;

  localparam int SCAN = 144;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce, rd_n, wr_n;
  logic [15:0] ad;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        data_oe;
  logic [7:0]  kbd_row_n;
  logic [4:0]  kbd_col_n;
  logic        ear_in;
  logic [2:0]  border;
  logic        mic_out, ear_out;
  logic        int_n, frame_start;
  logic        enter_down;

  int n_cmp = 0;
  int n_bad = 0;
  string       tag_q[$];
  logic [15:0] exp_q[$];

  zx_ula_port_ctrl #(
    .FRAME_CYCLES(100), .INT_CYCLES(4), .SETTLE_CYCLES(16), .DEBOUNCE_SCANS(3)
  ) dut (
    .clk(clk), .reset(reset), .ce(ce), .rd_n(rd_n), .wr_n(wr_n), .ad(ad),
    .data_in(data_in), .data_out(data_out), .data_oe(data_oe),
    .kbd_row_n(kbd_row_n), .kbd_col_n(kbd_col_n), .ear_in(ear_in),
    .border(border), .mic_out(mic_out), .ear_out(ear_out),
    .int_n(int_n), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // ENTER sits on row 6 (A14), column 0.
  assign kbd_col_n = (enter_down && kbd_row_n == 8'hBF) ? 5'h1E : 5'h1F;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [15:0] e);
    tag_q.push_back(tag);
    exp_q.push_back(e);
  endtask

  task automatic check(input logic [15:0] obs);
    string       t;
    logic [15:0] e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $error("FAIL sb_empty observed=%h expected=<none>", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_bad++;
        $error("FAIL %s observed=%h expected=%h", t, obs, e);
      end
    end
  endtask

  task automatic bus_idle();
    ce = 1'b1; rd_n = 1'b1; wr_n = 1'b1; ad = 16'hFFFF;
  endtask

  task automatic read_chk(input string tag, input logic [15:0] a, input logic [7:0] e);
    ce = 1'b0; rd_n = 1'b0; wr_n = 1'b1; ad = a;
    push(tag, {8'h00, e});
    #1;
    check({8'h00, data_out});
    push({tag, "_oe"}, 16'd1);
    check({15'd0, data_oe});
    bus_idle();
  endtask

  initial begin
    logic       ok;
    logic [7:0] prev;
    logic [7:0] e8;

    reset = 1'b0; enter_down = 1'b0; ear_in = 1'b1; data_in = 8'h00;
    bus_idle();
    repeat (3) tick();

    // Reset state
    push("rst_int_n", 16'd1);    check({15'd0, int_n});
    push("rst_fstart", 16'd0);   check({15'd0, frame_start});
    push("rst_row_n", 16'h00FE); check({8'h00, kbd_row_n});
    push("rst_border", 16'd0);   check({13'd0, border});
    push("rst_mic", 16'd0);      check({15'd0, mic_out});
    push("rst_ear", 16'd0);      check({15'd0, ear_out});

    // Release and follow two short frames plus the first row strobes.
    reset = 1'b1;
    for (int c = 0; c < 205; c++) begin
      tick();
      push("frame_start", {15'd0, (c % 100) == 0});
      check({15'd0, frame_start});
      push("int_n", {15'd0, !((c % 100) < 4)});
      check({15'd0, int_n});
      if (c == 0)  begin push("row_c0", 16'h00FE);  check({8'h00, kbd_row_n}); end
      if (c == 16) begin push("row_c16", 16'h00FF); check({8'h00, kbd_row_n}); end
      if (c == 17) begin push("row_c17", 16'h00FD); check({8'h00, kbd_row_n}); end
    end

    // Idle keyboard reads and port address decode
    read_chk("rd_7ffe", 16'h7FFE, 8'hFF);
    ce = 1'b0; rd_n = 1'b0; wr_n = 1'b1; ad = 16'h7FFF;
    push("oe_a0_high", 16'd0);
    #1 check({15'd0, data_oe});
    bus_idle();
    ear_in = 1'b0;
    read_chk("rd_ear0", 16'h7FFE, 8'hBF);
    ear_in = 1'b1;

    // ENTER press
    enter_down = 1'b1;
    repeat (5 * SCAN) tick();
    read_chk("press_bffe", 16'hBFFE, 8'hFE);
    read_chk("press_00fe", 16'h00FE, 8'hFE);
    read_chk("press_fefe", 16'hFEFE, 8'hFF);
    read_chk("press_7ffe", 16'h7FFE, 8'hFF);

    // ENTER release
    enter_down = 1'b0;
    repeat (5 * SCAN) tick();
    read_chk("release_bffe", 16'hBFFE, 8'hFF);

    // Align to the start of row 0, then toggle ENTER once per scan.
    ok = 1'b0;
    prev = kbd_row_n;
    for (int k = 0; k < 400; k++) begin
      tick();
      if (kbd_row_n == 8'hFE && prev != 8'hFE) begin ok = 1'b1; break; end
      prev = kbd_row_n;
    end
    push("align_row0", 16'd1);
    check({15'd0, ok});
    for (int i = 0; i < 10; i++) begin
      enter_down = (i % 2) == 1;
      repeat (SCAN) tick();
`ifdef ZX_KBD_DEBOUNCE_EN
      e8 = 8'hFF;
`else
      e8 = ((i % 2) == 1) ? 8'hFE : 8'hFF;
`endif
      read_chk("toggle_bffe", 16'hBFFE, e8);
    end
    enter_down = 1'b0;
    repeat (5 * SCAN) tick();
    read_chk("after_toggle", 16'hBFFE, 8'hFF);

    // OUT with strobe held 5 cycles; data changes after the first must not land.
    ce = 1'b0; rd_n = 1'b1; wr_n = 1'b0; ad = 16'h00FE; data_in = 8'h1D;
    tick();
    push("wr_border_1st", 16'd5); check({13'd0, border});
    data_in = 8'h00;
    repeat (4) tick();
    push("wr_border_hold", 16'd5); check({13'd0, border});
    push("wr_mic_hold", 16'd1);    check({15'd0, mic_out});
    push("wr_ear_hold", 16'd1);    check({15'd0, ear_out});
    bus_idle();
    tick();

    // Both strobes low: neither read nor write fires.
    ce = 1'b0; rd_n = 1'b0; wr_n = 1'b0; ad = 16'h00FE; data_in = 8'h02;
    push("both_low_oe", 16'd0);
    #1 check({15'd0, data_oe});
    repeat (3) tick();
    push("both_low_border", 16'd5); check({13'd0, border});
    push("both_low_mic", 16'd1);    check({15'd0, mic_out});
    bus_idle();
    tick();

    // A fresh write after release captures again.
    ce = 1'b0; rd_n = 1'b1; wr_n = 1'b0; ad = 16'h00FE; data_in = 8'h02;
    tick();
    bus_idle();
    push("wr2_border", 16'd2); check({13'd0, border});
    push("wr2_mic", 16'd0);    check({15'd0, mic_out});
    push("wr2_ear", 16'd0);    check({15'd0, ear_out});

    // Reset at row 5 during /INT with ENTER held and registered.
    enter_down = 1'b1;
    repeat (5 * SCAN) tick();
    read_chk("pre_rst_00fe", 16'h00FE, 8'hFE);
    ok = 1'b0;
    for (int k = 0; k < 20000; k++) begin
      tick();
      if (kbd_row_n == 8'hDF && int_n == 1'b0) begin ok = 1'b1; break; end
    end
    push("find_row5_int", 16'd1);
    check({15'd0, ok});
    reset = 1'b0;
    tick();
    push("mid_rst_int_n", 16'd1);    check({15'd0, int_n});
    push("mid_rst_row_n", 16'h00FE); check({8'h00, kbd_row_n});
    push("mid_rst_border", 16'd0);   check({13'd0, border});
    push("mid_rst_fstart", 16'd0);   check({15'd0, frame_start});
    read_chk("mid_rst_00fe", 16'h00FE, 8'hFF);
    read_chk("mid_rst_bffe", 16'hBFFE, 8'hFF);
    reset = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/zx_ula_port_ctrl.md
# zx_ula_port_ctrl

ULA-side controller for Spectrum port FE and the frame interrupt. Scans a physical 8×5 key matrix with a row-strobe state machine, debounces it into a 40-bit key-state register, and answers CPU `IN` on port FE with the half-row combination selected by A15..A8. It latches border/MIC/EAR on `OUT` and generates the periodic 50 Hz `/INT` pulse. It sits between the Z80 bus, the keyboard connector and the video/audio blocks.

## Interface
- `FRAME_CYCLES`, 69888: `clk` cycles per video frame (interrupt period).
- `INT_CYCLES`, 32: `/INT` low width in cycles; must be ≥1 and < `FRAME_CYCLES`.
- `SETTLE_CYCLES`, 16: cycles a row strobe is held before its columns are sampled; ≥1.
- `DEBOUNCE_SCANS`, 3: consecutive identical samples required to accept a row change; ≥1.

- `clk` in 1: single system clock.
- `reset` in 1: synchronous, active-low reset.
- `ce` in 1: I/O chip select, active low.
- `rd_n` in 1: CPU read strobe, active low.
- `wr_n` in 1: CPU write strobe, active low.
- `ad` in 16: CPU address bus.
- `data_in` in 8: CPU data for `OUT`.
- `data_out` out 8: port FE read value.
- `data_oe` out 1: high while `data_out` must drive the bus.
- `kbd_row_n` out 8: row strobes, at most one low.
- `kbd_col_n` in 5: column returns, low = key pressed on the strobed row.
- `ear_in` in 1: tape input.
- `border` out 3: border colour.
- `mic_out`, `ear_out` out 1: the two port FE output bits.
- `int_n` out 1: frame interrupt, active low.
- `frame_start` out 1: one-cycle pulse at frame counter 0.

## Operation
- Read decode: `rd_sel = !ce & !rd_n & wr_n & !ad[0]`. `data_oe = rd_sel`, combinational.
- `data_out = {1'b1, ear_in, 1'b1, K}`. `K[c]` is the AND over all rows r with `ad[8+r]==0` of `keys[r][c]`. If no address bit is low, `K = 5'b11111`. The output is combinational from registered `keys`.
- Write decode: `wr_sel = !ce & !wr_n & rd_n & !ad[0]`. On the first cycle `wr_sel` is true (the previous cycle's value was false), capture `border<=data_in[2:0]`, `mic_out<=data_in[3]`, `ear_out<=data_in[4]`. Holding the strobe low does not re-capture.
- If `rd_n` and `wr_n` are both low, neither the read nor the write decode fires.
- Scanner FSM:
  - DRIVE: `kbd_row_n = ~(1<<row)`. Count `SETTLE_CYCLES`, then go to SAMPLE.
  - SAMPLE: one cycle. Register `kbd_col_n` as `samp`, apply debounce, go to NEXT.
  - NEXT: one cycle with all strobes high. `row <= row+1`, wrapping 7→0, then go to DRIVE.
- Debounce, per row: a 5-bit `last[r]` and a counter `cnt[r]`.
  - If `samp != last[r]`: `last[r] <= samp`, `cnt[r] <= 1`.
  - Otherwise `cnt[r]` saturates at `DEBOUNCE_SCANS`. When it reaches `DEBOUNCE_SCANS`, `keys[r] <= last[r]`.
- Frame timer: `fcnt` counts 0..`FRAME_CYCLES-1` and wraps. `int_n = 0` while `fcnt < INT_CYCLES`. `frame_start = (fcnt == 0)`. `int_n` and `frame_start` are registered outputs.

## Timing
- Reset values (cycle after `reset` sampled low):
  - `keys` all 1, `last` all 1, `cnt` 0.
  - `row` 0, FSM in DRIVE with settle count 0. `kbd_row_n = 8'hFE` from the first cycle after reset.
  - `border` 0, `mic_out` 0, `ear_out` 0.
  - `fcnt` 0, `int_n` 1, `frame_start` 0.
  - Write-edge history cleared.
- Reset mid-scan or mid-pulse abandons the current row and pulse immediately.
- After reset release, `frame_start` pulses on the first clock edge; `int_n` is low for cycles 0..`INT_CYCLES-1`.
- One row visit takes `SETTLE_CYCLES+2` cycles; a full scan takes `8*(SETTLE_CYCLES+2)` cycles (144 at defaults).
- Key press latency, worst case: (`DEBOUNCE_SCANS`+1) full scans plus 1 cycle. The release path has the same latency.
- Bounce resets the row counter; a row that alternates every scan never updates `keys`.
- Write capture happens 1 cycle after the qualifying edge. Read data is valid in the same cycle `rd_sel` rises.

## Configuration
- `ZX_KBD_DEBOUNCE_EN` defined: debounce as in Operation.
- Not defined: SAMPLE writes `keys[row] <= samp` directly. `last` and `cnt` are not built, and `DEBOUNCE_SCANS` is ignored. Latency is at most 1 scan plus 1 cycle.

## Test plan
- Reset with `kbd_col_n=5'h1F`, then read `ad=16'h7FFE` with `ce=0`, `rd_n=0`, `wr_n=1`, `ear_in=1` → `data_out=8'hFF`, `data_oe=1`. Same bus cycle with `ad[0]=1` → `data_oe=0`.
- Hold `kbd_col_n[0]=0` only while `kbd_row_n=8'hBF` (ENTER), default params → after ≤4 scans `ad=16'hBFFE` reads `8'hFE`, `ad=16'h00FE` reads `8'hFE`, `ad=16'hFEFE` reads `8'hFF`.
- Toggle the ENTER column every scan for 10 scans → `keys[6]` stays `5'h1F`. With `ZX_KBD_DEBOUNCE_EN` undefined, the read follows each scan.
- `OUT` with `data_in=8'h1D`, `ad=16'h00FE`, `wr_n` held low 5 cycles → `border=3'd5`, `mic_out=1`, `ear_out=1`, captured exactly once. A later write of `8'h02` with `rd_n` also low → no change.
- Run 2 frames with `FRAME_CYCLES=100`, `INT_CYCLES=4` → `int_n` low for cycles 0–3 and 100–103, `frame_start` high at cycles 0 and 100.
- Assert `reset` low at scan row 5, mid-`/INT` → next cycle `int_n=1`, `kbd_row_n=8'hFE`, `border=0`, all reads return `8'hFF` with `ear_in=1`.
